// File: rtl/timer_input_ctrl.sv
// Input conditioning and 1 Hz timebase for the two-digit countdown timer:
// synchronizes/debounces the pause button and preset switch, and divides clkin into tick.

module timer_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic clkin,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Two-flop synchronizer followed by a level that only moves after a full stable run.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      level <= RST_VAL;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

module timer_input_ctrl #(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clkin,
  input  logic reset,
  input  logic pause_n,
  input  logic s,
  output logic tick,
  output logic paused,
  output logic pause_pulse,
  output logic s_db,
  output logic preset_load
);

  localparam int unsigned TD_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);

  logic            pause_db;
  logic            pause_db_d;
  logic            s_db_d;
  logic [TD_W-1:0] div_cnt;
  logic            pause_fall_c;
  logic            s_chg_c;

  timer_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_pause_db (
    .clkin(clkin),
    .reset(reset),
    .din  (pause_n),
    .level(pause_db)
  );

  timer_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b0)
  ) u_s_db (
    .clkin(clkin),
    .reset(reset),
    .din  (s),
    .level(s_db)
  );

  assign pause_fall_c = pause_db_d & ~pause_db;
  assign s_chg_c      = s_db_d ^ s_db;

  // Edge strobes, pause toggle and prescaler; the prescaler sees paused from before the edge.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      pause_db_d  <= 1'b1;
      s_db_d      <= 1'b0;
      pause_pulse <= 1'b0;
      paused      <= 1'b0;
      preset_load <= 1'b0;
      div_cnt     <= '0;
      tick        <= 1'b0;
    end else begin
      pause_db_d  <= pause_db;
      s_db_d      <= s_db;
      pause_pulse <= pause_fall_c;
      paused      <= paused ^ pause_fall_c;
      preset_load <= s_chg_c;
      if (s_chg_c) begin
        div_cnt <= '0;
        tick    <= 1'b0;
      end else if (paused) begin
        tick <= 1'b0;
      end else if (div_cnt == TD_LAST) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + TD_W'(1);
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Bench for timer_input_ctrl: directed scenarios plus random stimulus against an event-level model.

module tb_timer_input_ctrl;

  localparam int unsigned TD = 10;
  localparam int unsigned DB = 4;

  logic clkin;
  logic reset;
  logic pause_n;
  logic s;
  logic tick;
  logic paused;
  logic pause_pulse;
  logic s_db;
  logic preset_load;

  int n_cmp;
  int n_bad;

  // Reference model state: raw-sample history, debounced levels, run lengths, second phase.
  bit hp[$];
  bit hs[$];
  bit pst, pst_prev, sst, sst_prev;
  int prun, srun, phase;
  bit e_tick, e_paused, e_pulse, e_sdb, e_load;

  timer_input_ctrl #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .pause_n    (pause_n),
    .s          (s),
    .tick       (tick),
    .paused     (paused),
    .pause_pulse(pause_pulse),
    .s_db       (s_db),
    .preset_load(preset_load)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hp = {1'b1, 1'b1};
    hs = {1'b0, 1'b0};
    pst = 1'b1; pst_prev = 1'b1;
    sst = 1'b0; sst_prev = 1'b0;
    prun = 0; srun = 0; phase = 0;
    e_tick = 0; e_paused = 0; e_pulse = 0; e_sdb = 0; e_load = 0;
  endfunction

  // A level changes once the input has disagreed with it for DB consecutive samples.
  function automatic void deb(input bit seen, inout bit lvl, inout int run);
    if (seen == lvl) run = 0;
    else begin
      run++;
      if (run == DB) begin
        lvl = seen;
        run = 0;
      end
    end
  endfunction

  function automatic void model_edge();
    bit seen_p, seen_s, fall, chg, old_paused;
    old_paused = e_paused;
    fall = pst_prev & ~pst;
    chg  = sst_prev ^ sst;
    e_pulse  = fall;
    e_paused = e_paused ^ fall;
    e_load   = chg;
    if (chg) begin
      phase  = 0;
      e_tick = 0;
    end else if (old_paused) begin
      e_tick = 0;
    end else begin
      phase++;
      e_tick = (phase == TD);
      if (e_tick) phase = 0;
    end
    pst_prev = pst;
    sst_prev = sst;
    seen_p = hp.pop_front();
    hp.push_back(pause_n);
    seen_s = hs.pop_front();
    hs.push_back(s);
    deb(seen_p, pst, prun);
    deb(seen_s, sst, srun);
    e_sdb = sst;
  endfunction

  task automatic check_outputs();
    chk("tick",        32'(tick),        32'(e_tick));
    chk("paused",      32'(paused),      32'(e_paused));
    chk("pause_pulse", 32'(pause_pulse), 32'(e_pulse));
    chk("s_db",        32'(s_db),        32'(e_sdb));
    chk("preset_load", 32'(preset_load), 32'(e_load));
  endtask

  task automatic cycle();
    @(posedge clkin);
    if (reset) model_edge();
    #1;
    check_outputs();
  endtask

  // Called right after cycle(): asserts reset between edges and checks the immediate clear.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
  endtask

  task automatic press(output int first, output int cnt);
    first = 0;
    cnt   = 0;
    pause_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (pause_pulse) begin
        cnt++;
        if (first == 0) first = i;
      end
      if (i == 10) pause_n = 1'b1;
    end
  endtask

  task automatic first_tick_after_release(input string tag);
    int t1, t2;
    t1 = 0;
    t2 = 0;
    reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (tick) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
    end
    chk(tag, 32'(t1), 32'(TD));
    chk({tag, "_period"}, 32'(t2 - t1), 32'(TD));
  endtask

  initial begin
    int first, cnt, nt, isdb, il, it, hold;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset   = 1'b0;
    pause_n = 1'b1;
    s       = 1'b0;

    // Held in reset with random inputs: outputs stay low.
    repeat (4) begin
      pause_n = 1'($urandom_range(0, 1));
      s       = 1'($urandom_range(0, 1));
      cycle();
    end
    pause_n = 1'b1;
    s       = 1'b0;
    cycle();
    first_tick_after_release("first_tick");

    // Short glitch is rejected.
    pause_n = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle();
      if (pause_pulse) cnt++;
      if (i == 3) pause_n = 1'b1;
    end
    chk("glitch_pulses", 32'(cnt), 32'd0);
    chk("glitch_paused", 32'(paused), 32'd0);

    // Real press: one strobe, 7 edges after the fall.
    press(first, cnt);
    chk("press_latency", 32'(first), 32'd7);
    chk("press_count", 32'(cnt), 32'd1);
    chk("press_paused", 32'(paused), 32'd1);

    // Frozen: no ticks.
    nt = 0;
    repeat (25) begin
      cycle();
      if (tick) nt++;
    end
    chk("freeze_ticks", 32'(nt), 32'd0);

    press(first, cnt);
    chk("resume_paused", 32'(paused), 32'd0);
    repeat (15) cycle();

    // Preset change: s_db after 6, preset_load after 7, tick 10 after the load.
    s = 1'b1;
    isdb = 0; il = 0; it = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (s_db && isdb == 0) isdb = i;
      if (preset_load && il == 0) il = i;
      if (tick && il != 0 && i > il && it == 0) it = i;
    end
    chk("preset_sdb", 32'(isdb), 32'd6);
    chk("preset_load", 32'(il), 32'd7);
    chk("preset_tick", 32'(it - il), 32'(TD));
    s = 1'b0;
    cnt = 0;
    repeat (15) begin
      cycle();
      if (preset_load) cnt++;
    end
    chk("preset_back", 32'(cnt), 32'd1);

    // Reset while paused clears immediately; timebase restarts from zero.
    press(first, cnt);
    repeat (3) cycle();
    async_reset();
    chk("rst_paused", 32'(paused), 32'd0);
    repeat (2) cycle();
    first_tick_after_release("rst_first_tick");

    // Random pushes, switch flips and occasional resets.
    for (int k = 0; k < 400; k++) begin
      hold    = int'($urandom_range(1, 12));
      pause_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) s = ~s;
      repeat (hold) cycle();
      if ($urandom_range(0, 60) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) cycle();
        reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_input_ctrl.md
# timer_input_ctrl

Input-conditioning and timebase stage that sits directly upstream of the two-digit countdown timer. It synchronizes and debounces the raw pause pushbutton and preset slide switch. It converts each pause press into a pause/run toggle and divides the 50 MHz board clock into a single-cycle `tick` enable. The countdown consumes `tick`, `paused`, `s_db` and `preset_load`, and no longer needs its own 32-bit prescaler or button-edge logic.

## Interface
- `TICK_DIV`, 50000000: clock cycles per `tick` (1 Hz at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronized input must differ from its debounced level before that level changes (10 ms at 50 MHz); must be ≥ 2.
- `clkin` in 1: board clock; all state is rising-edge.
- `reset` in 1: asynchronous, active-low reset; clears all state immediately.
- `pause_n` in 1: raw pushbutton, active-low (0 = pressed), asynchronous to `clkin`.
- `s` in 1: raw preset-select slide switch, asynchronous to `clkin`.
- `tick` out 1: one-cycle enable, period `TICK_DIV` cycles while running.
- `paused` out 1: 1 = countdown frozen; toggles on each debounced press.
- `pause_pulse` out 1: one-cycle strobe per debounced press.
- `s_db` out 1: debounced preset select.
- `preset_load` out 1: one-cycle strobe when `s_db` changes; the downstream block reloads its start value.

## Operation
- Synchronizers: two flops each on `pause_n` and `s`. Reset values are 1 for `pause_n` (released) and 0 for `s`.
- Debouncers: `pause_n` and `s` each use an identical, independent debouncer.
  - Each has a stable-level register and a counter of width clog2(DEBOUNCE_CYCLES).
  - Synced value equals stable: counter := 0.
  - Synced value differs and counter < DEBOUNCE_CYCLES-1: counter += 1.
  - Synced value differs and counter == DEBOUNCE_CYCLES-1: stable := synced, counter := 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no output change.
- Pause edge: `pause_pulse` is registered and asserts for one cycle after the debounced pause level falls 1→0.
  - Release (0→1) produces nothing.
  - `paused` toggles on the same edge that asserts `pause_pulse`.
- Preset edge: `preset_load` is registered and asserts for one cycle after `s_db` changes in either direction.
- Prescaler: counter `div_cnt` has width clog2(TICK_DIV).
  - Clear: on the edge that asserts `preset_load`, div_cnt := 0 and `tick` := 0. Clear has priority over everything else.
  - Run (old `paused` == 0, div_cnt < TICK_DIV-1): div_cnt += 1, `tick` := 0.
  - Wrap (old `paused` == 0, div_cnt == TICK_DIV-1): div_cnt := 0, `tick` := 1.
  - Frozen (old `paused` == 1): div_cnt holds, `tick` := 0. Resume continues the partial second; it does not restart it.
- The prescaler uses the value of `paused` from before the edge. A wrap on the same edge that sets `paused` therefore still emits `tick`.
- All outputs are registered; there are no combinational input-to-output paths.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - All outputs = 0.
  - Debounced pause level = 1, `s_db` = 0.
  - All counters = 0.
- `reset` deassertion is taken as already synchronized to `clkin` by the board-level reset logic.
- Reset mid-operation: any partial debounce count or partial prescaler count is discarded.
- Latency, raw `pause_n` fall (held stable) to `pause_pulse`/`paused` change: 2 (sync) + DEBOUNCE_CYCLES + 1 edges.
- Latency, raw `s` change (held stable) to `s_db` change: 2 (sync) + DEBOUNCE_CYCLES edges. `preset_load` follows one edge later.
- `tick` spacing while running is exactly `TICK_DIV` cycles. The first `tick` after reset or `preset_load` arrives `TICK_DIV` edges later.
- Simultaneous `pause_pulse` and `preset_load`: `paused` toggles and the prescaler clears. These are independent and both occur.

## Test plan
Parameters for all scenarios: TICK_DIV=10, DEBOUNCE_CYCLES=4.
- Reset: hold `reset`=0 with random inputs → all outputs 0. Release `reset` with `pause_n`=1, `s`=0 → first `tick` 10 cycles after release, then every 10 cycles.
- Debounce: pulse `pause_n` low for 3 cycles → no `pause_pulse`, `paused` stays 0. Hold low for 10 cycles → exactly one `pause_pulse` and `paused`=1, asserted 7 edges after the fall.
- Freeze: press once when div_cnt=6 → `tick` stops and div_cnt holds at its value. Press again → first `tick` arrives after the remaining count, not a full 10 cycles.
- Wrap collision: time a press so `paused` sets on the div_cnt=9 edge → that `tick` still asserts, then no further ticks.
- Preset: toggle `s` 0→1 mid-count → `s_db`=1 after 6 edges, `preset_load` one cycle later, div_cnt=0, next `tick` 10 cycles after `preset_load`. Toggle back → second `preset_load`.
- Reset mid-operation: assert `reset` while paused with div_cnt=5 → `paused`=0 immediately. After release, first `tick` arrives at 10 cycles.
